// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory read port plus the
// valid/ready head-of-queue path towards decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_prefetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             dec_valid;
    logic             dec_ready;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4_out;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output dec_valid,
        output instr_out,
        output pc_out,
        output pc_plus4_out,
        input  dec_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  dec_valid,
        input  instr_out,
        input  pc_out,
        input  pc_plus4_out,
        output dec_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end with a small prefetch queue.
// Holds the PC, issues word reads to a 1-cycle-latency instruction memory,
// buffers {instr, pc, pc+4} and hands entries to decode via valid/ready.
// A redirect from execute flushes the queue and any in-flight read, then
// restarts fetch at the word-aligned target.
// Optional macro FETCH_PERF_CNT_EN adds saturating flush/stall counters.
module fetch_prefetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    fetch_prefetch_queue_if.master   bus,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              flush_count,
    output logic [31:0]              stall_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0]      CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP      = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK   = ~(WIDTH'(3));
    localparam logic [CW-1:0]    CNT_ZERO     = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE      = CW'(1);
    localparam logic [PW-1:0]    PTR_ZERO     = PW'(0);
    localparam logic [PW-1:0]    PTR_ONE      = PW'(1);
    localparam logic [WIDTH-1:0] WORD_ZERO    = {WIDTH{1'b0}};

    // Queue storage
    logic [WIDTH-1:0] instr_mem_r [DEPTH];
    logic [WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [WIDTH-1:0] pc4_mem_r   [DEPTH];

    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    // Fetch state
    logic [WIDTH-1:0] pc_r;
    logic             inflight_r;
    logic [WIDTH-1:0] inflight_pc_r;
    logic             squash_r;

    // Per-cycle decisions
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [WIDTH-1:0] head_instr_s;
    logic [WIDTH-1:0] head_pc_s;
    logic [WIDTH-1:0] head_pc4_s;

    // Issue credit and queue push/pop qualification; redirect overrides all
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (rst && !redirect &&
            (({1'b0, count_r} + {{CW{1'b0}}, inflight_r}) < CREDIT_LIMIT)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (!redirect) begin
            push_s = inflight_r & ~squash_r;
            pop_s  = (count_r != CNT_ZERO) & bus.dec_ready;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Head-of-queue view; an empty queue presents an all-zero bubble
    always_comb begin
        head_valid_s = 1'b0;
        head_instr_s = WORD_ZERO;
        head_pc_s    = WORD_ZERO;
        head_pc4_s   = WORD_ZERO;
        if (count_r != CNT_ZERO) begin
            head_valid_s = 1'b1;
            head_instr_s = instr_mem_r[rd_ptr_r];
            head_pc_s    = pc_mem_r[rd_ptr_r];
            head_pc4_s   = pc4_mem_r[rd_ptr_r];
        end else begin
            head_valid_s = 1'b0;
        end
    end

    assign bus.imem_req     = issue_s;
    assign bus.imem_addr    = pc_r;
    assign bus.dec_valid    = head_valid_s;
    assign bus.instr_out    = head_instr_s;
    assign bus.pc_out       = head_pc_s;
    assign bus.pc_plus4_out = head_pc4_s;
    assign occupancy        = count_r;

    // PC, in-flight tracking and queue pointers/occupancy/storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= WORD_ZERO;
            squash_r      <= 1'b0;
            rd_ptr_r      <= PTR_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= WORD_ZERO;
                pc_mem_r[i]    <= WORD_ZERO;
                pc4_mem_r[i]   <= WORD_ZERO;
            end
        end else if (redirect) begin
            // Flush everything; the read that might still be returning is
            // marked for one cycle so it can never reach the queue.
            pc_r       <= redirect_pc & ALIGN_MASK;
            inflight_r <= 1'b0;
            squash_r   <= 1'b1;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            squash_r   <= 1'b0;
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r          <= pc_r + PC_STEP;
                inflight_pc_r <= pc_r;
            end
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
                pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
                pc4_mem_r[wr_ptr_r]   <= inflight_pc_r + PC_STEP;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_count_r;
    logic [31:0] stall_count_r;

    // Saturating counts of redirect cycles and decode back-pressure cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_count_r <= 32'h0000_0000;
            stall_count_r <= 32'h0000_0000;
        end else begin
            if (redirect && (flush_count_r != 32'hFFFF_FFFF)) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
            if (head_valid_s && !bus.dec_ready && (stall_count_r != 32'hFFFF_FFFF)) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign flush_count = flush_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a directed vector table for
// the start-up sequence, hand-written corner sequences, and a randomized run
// compared every cycle against a queue-based behavioural model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  occupancy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flush_count;
    logic [31:0] stall_count;
`endif

    fetch_prefetch_queue_if #(.WIDTH(32)) bus_if ();

    fetch_prefetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus_if.master),
        .occupancy   (occupancy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .flush_count (flush_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds k+1
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    // Synchronous instruction memory, one cycle of read latency
    always @(posedge clk) begin
        if (bus_if.imem_req) bus_if.imem_rdata <= rom(bus_if.imem_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Behavioural model: queue of buffered PCs plus one outstanding read
    logic [31:0] m_q[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic [31:0] m_flush;
    logic [31:0] m_stall;

    // Last values sampled at the falling edge
    logic        s_valid, s_req;
    logic [31:0] s_pc, s_addr;
    logic [2:0]  s_occ;

    function automatic bit model_req();
        return !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_pc      = 32'h0;
        m_flush   = 32'h0;
        m_stall   = 32'h0;
    endtask

    task automatic sample();
        s_valid = bus_if.dec_valid;
        s_req   = bus_if.imem_req;
        s_pc    = bus_if.pc_out;
        s_addr  = bus_if.imem_addr;
        s_occ   = occupancy;
    endtask

    task automatic model_check();
        bit          v;
        logic [31:0] hp;
        v  = (m_q.size() != 0);
        hp = v ? m_q[0] : 32'h0;
        check("imem_req",     {31'd0, bus_if.imem_req}, {31'd0, model_req()});
        check("imem_addr",    bus_if.imem_addr, m_pc);
        check("dec_valid",    {31'd0, bus_if.dec_valid}, {31'd0, v});
        check("pc_out",       bus_if.pc_out, hp);
        check("instr_out",    bus_if.instr_out, v ? rom(hp) : 32'h0);
        check("pc_plus4_out", bus_if.pc_plus4_out, v ? hp + 32'd4 : 32'h0);
        check("occupancy",    {29'd0, occupancy}, m_q.size());
`ifdef FETCH_PERF_CNT_EN
        check("flush_count",  flush_count, m_flush);
        check("stall_count",  stall_count, m_stall);
`endif
        sample();
    endtask

    task automatic model_step();
        bit req;
        req = model_req();
        if (redirect && m_flush != 32'hFFFF_FFFF) m_flush++;
        if (m_q.size() != 0 && !bus_if.dec_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_q.size() != 0 && bus_if.dec_ready) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = req;
            if (req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, advance model
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
        redirect         = redir;
        redirect_pc      = rpc;
        bus_if.dec_ready = rdy;
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        redirect         = 1'b0;
        bus_if.dec_ready = 1'b0;
        #2;
        check("rst imem_req",  {31'd0, bus_if.imem_req}, 32'h0);
        check("rst dec_valid", {31'd0, bus_if.dec_valid}, 32'h0);
        check("rst instr_out", bus_if.instr_out, 32'h0);
        check("rst pc_out",    bus_if.pc_out, 32'h0);
        check("rst pc_plus4",  bus_if.pc_plus4_out, 32'h0);
        check("rst occupancy", {29'd0, occupancy}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst flush_count", flush_count, 32'h0);
        check("rst stall_count", stall_count, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    // Run n cycles with decode ready; report the first delivered PC and
    // how often a forbidden PC showed up at the head.
    task automatic watch(input int n, input logic [31:0] bad_pc,
                         output logic found, output logic [31:0] first, output int bad_hits);
        found    = 1'b0;
        first    = 32'h0;
        bad_hits = 0;
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid) begin
                if (!found) begin
                    found = 1'b1;
                    first = s_pc;
                end
                if (s_pc == bad_pc) bad_hits++;
            end
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_p4;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic        found;
        logic [31:0] first;
        int          hits;
        logic        r_redir;
        logic [31:0] r_pc;
        logic        r_rdy;

        vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0, 32'h00, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0, 32'h00, 3'd0};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h1, 32'h04, 3'd1};
        vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h2, 32'h08, 3'd1};
        vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h3, 32'h0C, 3'd1};
        vecs[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h4, 32'h10, 3'd1};

        bus_if.dec_ready = 1'b0;
        #1;
        do_reset();

        // Start-up sequence from the vector table
        for (int i = 0; i < 6; i++) begin
            redirect         = 1'b0;
            redirect_pc      = 32'h0;
            bus_if.dec_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("tbl[%0d] imem_req", i), {31'd0, bus_if.imem_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("tbl[%0d] imem_addr", i), bus_if.imem_addr, vecs[i].exp_addr);
            check($sformatf("tbl[%0d] dec_valid", i), {31'd0, bus_if.dec_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("tbl[%0d] pc_out", i), bus_if.pc_out, vecs[i].exp_pc);
            check($sformatf("tbl[%0d] instr_out", i), bus_if.instr_out, vecs[i].exp_instr);
            check($sformatf("tbl[%0d] pc_plus4", i), bus_if.pc_plus4_out, vecs[i].exp_p4);
            check($sformatf("tbl[%0d] occupancy", i), {29'd0, occupancy}, {29'd0, vecs[i].exp_occ});
            model_step();
            @(posedge clk);
            #1;
        end

        // Back-pressure: queue fills, fetch stops, then drains gap-free
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
        check("full occupancy", {29'd0, s_occ}, 32'd4);
        check("full imem_req",  {31'd0, s_req}, 32'h0);
        check("full head pc",   s_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check($sformatf("drain[%0d] valid", i), {31'd0, s_valid}, 32'h1);
            check($sformatf("drain[%0d] pc", i), s_pc, 32'(i * 4));
        end

        // Redirect with three queued entries and one read in flight
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0);
        check("pre-redirect occupancy", {29'd0, s_occ}, 32'd3);
        cycle(1'b0, 32'h0, 1'b1);
        check("post-redirect valid", {31'd0, s_valid}, 32'h0);
        check("post-redirect occ",   {29'd0, s_occ}, 32'h0);
        watch(8, 32'hC, found, first, hits);
        check("redirect found",    {31'd0, found}, 32'h1);
        check("redirect first pc", first, 32'h40);
        check("stale word hits",   32'(hits), 32'h0);

        // Unaligned target is word-aligned
        cycle(1'b1, 32'h43, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("unaligned req",  {31'd0, s_req}, 32'h1);
        check("unaligned addr", s_addr, 32'h40);
        watch(6, 32'h43, found, first, hits);
        check("unaligned first pc", first, 32'h40);

        // Back-to-back redirects: only the last target is fetched
        cycle(1'b1, 32'h100, 1'b1);
        cycle(1'b1, 32'h200, 1'b1);
        watch(8, 32'h100, found, first, hits);
        check("b2b found",    {31'd0, found}, 32'h1);
        check("b2b first pc", first, 32'h200);
        check("b2b 0x100 hits", 32'(hits), 32'h0);

        // PC wrap past the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("wrap addr top", s_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1);
        check("wrap addr zero", s_addr, 32'h0);
        watch(4, 32'h4, found, first, hits);
        check("wrap first pc", first, 32'hFFFF_FFFC);

`ifdef FETCH_PERF_CNT_EN
        // Five stall cycles and two redirects from a clean reset
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h80, 1'b1);
        cycle(1'b1, 32'h90, 1'b1);
        @(negedge clk);
        check("perf stall_count", stall_count, 32'd5);
        check("perf flush_count", flush_count, 32'd2);
        @(posedge clk);
        #1;
        model_step();
`endif

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            r_redir = ($urandom_range(0, 15) == 0);
            r_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            r_rdy   = ($urandom_range(0, 9) < 7);
            cycle(r_redir, r_pc, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
